// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: iterative radix-4 Booth multiplier, signed/unsigned.
// Ports: clk, rst_n, flush; in_valid/in_ready with a, b, signed_mode;
// out_valid/out_ready with product (2*WIDTH bits, exact).
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int ITERS = (WIDTH + 2) / 2;
    localparam int EW    = WIDTH + 2;
    localparam int HW    = WIDTH + 4;
    localparam int CW    = $clog2(ITERS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [EW-1:0] mcand;
    logic [EW-1:0] mreg;
    logic          prev;
    logic [HW-1:0] hi;

    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;
    logic [HW-1:0] m1;
    logic [HW-1:0] m2;
    logic [HW-1:0] addend;
    logic [HW-1:0] sum;
    logic [HW-1:0] hi_nxt;
    logic [EW-1:0] mreg_nxt;
    logic [2:0]    trip;

    // Two extra bits let the unsigned top bit be recoded as a
    // positive digit and keep -2^(W-1) exact in signed mode.
    assign a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};

    assign m1   = {{2{mcand[EW-1]}}, mcand};
    assign m2   = {m1[HW-2:0], 1'b0};
    assign trip = {mreg[1:0], prev};

    always_comb begin
        addend = '0;
        unique case (trip)
            3'b001, 3'b010: addend = m1;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m1;
            default:        addend = '0;
        endcase
    end

    assign sum = hi + addend;

    // {hi, mreg} acts as one register shifted right arithmetically by 2;
    // consumed multiplier bits drop off the bottom of mreg.
    assign hi_nxt   = {{2{sum[HW-1]}}, sum[HW-1:2]};
    assign mreg_nxt = {sum[1:0], mreg[EW-1:2]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mreg    <= '0;
            prev    <= 1'b0;
            hi      <= '0;
            product <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a_ext;
                        mreg  <= b_ext;
                        prev  <= 1'b0;
                        hi    <= '0;
                        cnt   <= CW'(ITERS);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    hi   <= hi_nxt;
                    mreg <= mreg_nxt;
                    prev <= mreg[1];
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        product <= {hi_nxt[WIDTH-3:0], mreg_nxt};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed and random checks of the 32-bit
// radix-4 Booth multiplier with immediate assertions.
module tb_seq_booth_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int compared   = 0;
    int mismatched = 0;

    seq_booth_multiplier #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'd0, x};
        ye = s ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    task automatic do_op(input string tag, input logic [31:0] x,
                         input logic [31:0] y, input logic s,
                         input logic [63:0] exp, input int stall);
        int n;
        a = x;
        b = y;
        signed_mode = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd17);
        chk({tag, "_product"}, product, exp);
        repeat (stall) tick();
        if (stall > 0) chk({tag, "_hold"}, product, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] held;
        int n;

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", product, 64'd0);
        rst_n = 1'b1;
        tick();

        do_op("s_7x-3", 32'd7, 32'hFFFF_FFFD, 1'b1,
              64'hFFFF_FFFF_FFFF_FFEB, 0);
        do_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1,
              64'h4000_0000_0000_0000, 0);
        do_op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1,
              64'hC000_0000_8000_0000, 2);
        do_op("u_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              64'hFFFF_FFFE_0000_0001, 0);
        do_op("s_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              64'd1, 0);
        do_op("u_min_min", 32'h8000_0000, 32'h8000_0000, 1'b0,
              64'h4000_0000_0000_0000, 1);
        do_op("u_zero", 32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0, 0);

        // Backpressure: product held, new request ignored.
        a = 32'd12345;
        b = 32'd678;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_latency", 64'(n), 64'd17);
        held = product;
        chk("bp_product", held, 64'd8369910);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3 || i == 4);
            a = 32'd99;
            b = 32'd99;
            tick();
            chk("bp_stable", product, 64'd8369910);
            chk("bp_in_ready", {62'd0, out_valid, in_ready}, 64'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {62'd0, out_valid, in_ready}, 64'd1);
        do_op("b2b_1", 32'hFFFF_FFF6, 32'd10, 1'b1,
              64'hFFFF_FFFF_FFFF_FF9C, 0);
        do_op("b2b_2", 32'h0001_0000, 32'h0001_0000, 1'b0,
              64'h0000_0001_0000_0000, 0);

        // Flush has priority over accept.
        a = 32'd3;
        b = 32'd3;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_accept", 64'(in_ready), 64'd1);

        // Flush in the 5th BUSY cycle.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid || !in_ready) n++;
            tick();
        end
        chk("flush_no_output", 64'(n), 64'd0);

        // Async reset in the 5th BUSY cycle.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_state", {62'd0, out_valid, in_ready}, 64'd1);
        chk("rst_mid_product", product, 64'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid || !in_ready) n++;
            tick();
        end
        chk("rst_no_output", 64'(n), 64'd0);
        do_op("post_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              64'd1, 0);

        // Random vectors in both modes against the reference model.
        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 50 == 0) x = 32'h8000_0000;
            if (i % 70 == 1) y = 32'hFFFF_FFFF;
            do_op("rand", x, y, 1'(i % 2), ref_mul(x, y, 1'(i % 2)),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
